// File: rtl/washing_machine_plant.sv
// washing_machine_plant
//   Behavioural appliance model that sits on the far side of the washing
//   machine controller. It turns actuator commands into the sensor feedback
//   the controller waits on. It also latches a sticky fault when the
//   controller drives an unsafe actuator combination.
//
// Handshake: there is no valid/ready traffic here. Every input is a level
//   sampled on each rising clk edge. Every output is a register that is
//   updated on that same edge.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   door_lock         door locked by controller
//   motor_on          drum motor command
//   fill_value_on     fill valve open
//   drain_value_on    drain valve open
//   soap_wash         controller in soap-wash phase
//   water_wash        controller in rinse phase
//   done              controller cycle complete (clears detergent and timers)
//   filled            level == LEVEL_MAX
//   detergent_added   detergent dispensed (sticky until done/reset)
//   cycle_timeout     wash/rinse agitation time elapsed
//   drained           level == 0
//   spin_timeout      spin time elapsed
//   level             current water level
//   phase             0 IDLE, 1 FILL, 2 WASH, 3 DRAIN, 4 SPIN, 7 FAULT (debug state)
//   fault             sticky illegal-actuation flag
module washing_machine_plant #(
  parameter int LEVEL_W     = 8,
  parameter int LEVEL_MAX   = 100,
  parameter int FILL_RATE   = 10,
  parameter int DRAIN_RATE  = 20,
  parameter int DET_CYCLES  = 2,
  parameter int WASH_CYCLES = 8,
  parameter int SPIN_CYCLES = 6,
  parameter int TIMER_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               door_lock,
  input  logic               motor_on,
  input  logic               fill_value_on,
  input  logic               drain_value_on,
  input  logic               soap_wash,
  input  logic               water_wash,
  input  logic               done,
  output logic               filled,
  output logic               detergent_added,
  output logic               cycle_timeout,
  output logic               drained,
  output logic               spin_timeout,
  output logic [LEVEL_W-1:0] level,
  output logic [2:0]         phase,
  output logic               fault
);

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_DRAIN = 3'd3,
    PH_SPIN  = 3'd4,
    PH_FAULT = 3'd7
  } phase_e;

  localparam logic [LEVEL_W-1:0] LMAX     = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W:0]   LMAX_EXT = (LEVEL_W+1)'(LEVEL_MAX);
  localparam logic [LEVEL_W:0]   FILL_EXT = (LEVEL_W+1)'(FILL_RATE);
  localparam logic [LEVEL_W-1:0] DRAIN_L  = LEVEL_W'(DRAIN_RATE);
  localparam logic [TIMER_W-1:0] DET_T    = TIMER_W'(DET_CYCLES);
  localparam logic [TIMER_W-1:0] WASH_T   = TIMER_W'(WASH_CYCLES);
  localparam logic [TIMER_W-1:0] SPIN_T   = TIMER_W'(SPIN_CYCLES);
  localparam logic [TIMER_W-1:0] T_ONE    = TIMER_W'(1);

  phase_e             phase_q, phase_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               filled_q, filled_d;
  logic               drained_q, drained_d;
  logic               det_q, det_d;
  logic               ct_q, ct_d;
  logic               st_q, st_d;
  logic               fault_q, fault_d;
  logic [TIMER_W-1:0] det_t_q, det_t_d;
  logic [TIMER_W-1:0] wash_t_q, wash_t_d;
  logic [TIMER_W-1:0] spin_t_q, spin_t_d;
  logic [LEVEL_W:0]   fill_sum;
  logic               level_full, level_empty, det_qual;

  // Rinse-phase indication is part of the controller interface. Agitation
  // timing does not depend on it, because WASH phase alone drives the timer.
  logic unused_inputs;
  assign unused_inputs = water_wash;

  always_comb begin
    level_d     = level_q;
    fill_sum    = {1'b0, level_q} + FILL_EXT;
    level_full  = (level_q == LMAX);
    level_empty = (level_q == '0);

    // Level integrator. It saturates at both ends. Opposing valves hold the level.
    if (fill_value_on && !drain_value_on) begin
      level_d = (fill_sum >= LMAX_EXT) ? LMAX : fill_sum[LEVEL_W-1:0];
    end else if (drain_value_on && !fill_value_on) begin
      level_d = (level_q <= DRAIN_L) ? '0 : level_q - DRAIN_L;
    end

    filled_d  = (level_d == LMAX);
    drained_d = (level_d == '0);

    fault_d = fault_q
            | (fill_value_on && drain_value_on)
            | (motor_on && !door_lock)
            | ((fill_value_on || !level_empty) && !door_lock && motor_on);

    // Phase uses the fault value being latched on this edge. FAULT therefore
    // appears together with the fault flag, not one cycle later.
    phase_d = PH_IDLE;
    if (fault_d)                                      phase_d = PH_FAULT;
    else if (fill_value_on)                           phase_d = PH_FILL;
    else if (drain_value_on && motor_on && level_empty) phase_d = PH_SPIN;
    else if (drain_value_on)                          phase_d = PH_DRAIN;
    else if (motor_on && level_full)                  phase_d = PH_WASH;

    // Detergent dispenser: it needs DET_CYCLES consecutive qualifying cycles.
    det_qual = soap_wash && level_full && !det_q;
    det_t_d  = '0;
    det_d    = det_q;
    if (det_qual) begin
      det_t_d = (det_t_q == DET_T) ? det_t_q : det_t_q + T_ONE;
      if (det_t_d == DET_T) det_d = 1'b1;
    end

    // The wash and spin timers follow the phase being entered on this edge.
    // Leaving the phase therefore clears them on the same edge.
    wash_t_d = '0;
    if (phase_d == PH_WASH) wash_t_d = (wash_t_q == WASH_T) ? wash_t_q : wash_t_q + T_ONE;
    ct_d = (wash_t_d == WASH_T);

    spin_t_d = '0;
    if (phase_d == PH_SPIN) spin_t_d = (spin_t_q == SPIN_T) ? spin_t_q : spin_t_q + T_ONE;
    st_d = (spin_t_d == SPIN_T);

    // Both end-of-cycle and fault blank every timer output. Level is unaffected.
    if (done || fault_d) begin
      det_t_d  = '0;
      wash_t_d = '0;
      spin_t_d = '0;
      det_d    = 1'b0;
      ct_d     = 1'b0;
      st_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= PH_IDLE;
      level_q   <= '0;
      filled_q  <= 1'b0;
      drained_q <= 1'b1;
      det_q     <= 1'b0;
      ct_q      <= 1'b0;
      st_q      <= 1'b0;
      fault_q   <= 1'b0;
      det_t_q   <= '0;
      wash_t_q  <= '0;
      spin_t_q  <= '0;
    end else begin
      phase_q   <= phase_d;
      level_q   <= level_d;
      filled_q  <= filled_d;
      drained_q <= drained_d;
      det_q     <= det_d;
      ct_q      <= ct_d;
      st_q      <= st_d;
      fault_q   <= fault_d;
      det_t_q   <= det_t_d;
      wash_t_q  <= wash_t_d;
      spin_t_q  <= spin_t_d;
    end
  end

  assign filled          = filled_q;
  assign detergent_added = det_q;
  assign cycle_timeout   = ct_q;
  assign drained         = drained_q;
  assign spin_timeout    = st_q;
  assign level           = level_q;
  assign phase           = phase_q;
  assign fault           = fault_q;

endmodule

// File: doc/washing_machine_plant.md
Name: washing_machine_plant

Overview:
Behavioural appliance model on the far side of the washing_machine controller's actuator/sensor interface. It consumes the controller's actuator outputs (door_lock, motor_on, fill_value_on, drain_value_on, soap_wash, water_wash, done) and produces the sensor feedback the controller waits on (filled, detergent_added, cycle_timeout, drained, spin_timeout). Closing the loop with this block lets the controller run end to end in simulation without hand-timed stimulus. It also flags illegal actuator combinations.

Parameters:
LEVEL_W, 8, width of the water-level counter
LEVEL_MAX, 100, level at which the drum is full; must be < 2**LEVEL_W
FILL_RATE, 10, level increment per cycle while filling
DRAIN_RATE, 20, level decrement per cycle while draining
DET_CYCLES, 2, cycles of soap_wash at full level before detergent_added
WASH_CYCLES, 8, cycles of agitation before cycle_timeout
SPIN_CYCLES, 6, cycles of spin before spin_timeout
TIMER_W, 8, width of the detergent, wash and spin timers

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
door_lock  input  1  door locked by controller
motor_on  input  1  drum motor command
fill_value_on  input  1  fill valve open
drain_value_on  input  1  drain valve open
soap_wash  input  1  controller in soap-wash phase
water_wash  input  1  controller in rinse phase
done  input  1  controller cycle complete
filled  output  1  level == LEVEL_MAX
detergent_added  output  1  detergent dispensed (sticky)
cycle_timeout  output  1  wash/rinse agitation time elapsed
drained  output  1  level == 0
spin_timeout  output  1  spin time elapsed
level  output  LEVEL_W  current water level
phase  output  3  0 IDLE, 1 FILL, 2 WASH, 3 DRAIN, 4 SPIN, 7 FAULT
fault  output  1  sticky illegal-actuation flag

Behaviour:
- All outputs registered. Reset values: level=0, drained=1, filled=0, detergent_added=0, cycle_timeout=0, spin_timeout=0, phase=IDLE, fault=0, all timers 0. Reset mid-operation returns to these values on the next edge.
- Level: fill only -> level+FILL_RATE, saturating at LEVEL_MAX. Drain only -> level-DRAIN_RATE, saturating at 0. Both or neither -> hold.
- filled and drained are decoded from the next level value, so both change on the same edge as level.
- Phase is re-evaluated every cycle with this priority:
  - FAULT if fault is set.
  - FILL if fill_value_on.
  - SPIN if drain_value_on && motor_on && level==0.
  - DRAIN if drain_value_on.
  - WASH if motor_on && level==LEVEL_MAX.
  - IDLE otherwise.
- Detergent timer:
  - Counts while soap_wash && level==LEVEL_MAX && !detergent_added.
  - When the timer reaches DET_CYCLES, detergent_added=1 on that edge (a DET_CYCLES-th consecutive qualifying cycle asserts it).
  - detergent_added stays high until done or reset.
  - The timer clears whenever the qualifying condition drops.
- Wash timer:
  - Counts in WASH phase; soap_wash or water_wash is not required.
  - At WASH_CYCLES it saturates and cycle_timeout=1.
  - Leaving WASH clears both the timer and cycle_timeout on the next edge.
- Spin timer: same rules as the wash timer, using SPIN phase, SPIN_CYCLES and spin_timeout.
- done=1: clears detergent_added and all three timers, and with them cycle_timeout and spin_timeout; level is unaffected.
- Fault: set on any cycle with
  - fill_value_on && drain_value_on, or
  - motor_on && !door_lock, or
  - (fill_value_on || level!=0) && !door_lock && motor_on.
  - Once set, fault is sticky until reset. Phase is forced to FAULT, the level still follows the valves, and the timer outputs are forced to 0.
- Timer widths: TIMER_W must hold max(DET_CYCLES, WASH_CYCLES, SPIN_CYCLES). All timers saturate and never wrap.

Test Plan:
- Reset held for 2 cycles then released, with fill_value_on=1 and door_lock=1 -> level goes 0,10,…,100 over 10 cycles; filled=1 on the 10th edge; drained=0 after the 1st edge; phase=FILL.
- Level 100, motor_on=1, door_lock=1, soap_wash=1 -> detergent_added=1 after 2 cycles; cycle_timeout=1 after 8 cycles; motor_on=0 -> cycle_timeout=0 on the next edge.
- Level 100, drain_value_on=1 -> level 80,60,…,0 in 5 cycles, drained=1; then motor_on=1 -> phase=SPIN and spin_timeout=1 after 6 cycles.
- fill_value_on=1 and drain_value_on=1 together for 1 cycle -> fault=1, phase=7, level held; fault persists after the valves drop until reset.
- motor_on=1 with door_lock=0 -> fault=1. Reset asserted mid-wash at level 60 -> level=0, drained=1, all flags 0 on the next edge.
- Full closed-loop run with a washing_machine instance, door_close=1, start=1 -> done asserted, fault stays 0 throughout.
